// File: rtl/api_pkg.sv
// -----------------------------------------------------------------------------
// api_pkg
// Shared definitions for the work-distribution SPI responder:
//   WORD_W        width of one work/result word
//   WORK_LEN_DEF  default number of words in a valid work frame
//   IDLE_WORD_DEF default word shifted out when the result queue is empty
//   state_t       frame FSM encoding (IDLE / ACTIVE / ERR)
//   pick_tx()     choose the next outgoing word from the FWFT result queue
// -----------------------------------------------------------------------------
package api_pkg;

  localparam int          WORD_W        = 32;
  localparam int          WORK_LEN_DEF  = 23;
  localparam logic [31:0] IDLE_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  // Next word for the transmit shifter: queue head if present, filler otherwise.
  function automatic logic [WORD_W-1:0] pick_tx(
    input logic              empty,
    input logic [WORD_W-1:0] head,
    input logic [WORD_W-1:0] idle
  );
    return empty ? idle : head;
  endfunction

endpackage

// File: rtl/api_spi_slave_if.sv
// -----------------------------------------------------------------------------
// api_spi_slave_if
// Bundles the serial link pins, the received-word stream and the result-queue
// handshake of the SPI responder.
//   load/sck/mosi/miso     serial link (controller side drives load/sck/mosi)
//   rx_data/rx_vld/rx_idx  received word stream, one-cycle strobe
//   frame_done/frame_err   end-of-frame status strobes
//   tx_data/tx_empty/tx_pop FWFT result queue head, empty flag and pop
// Modports: slave = the responder, master = controller + queue + consumer.
// -----------------------------------------------------------------------------
interface api_spi_slave_if #(
  parameter int IDX_W = 5
);

  logic             load;
  logic             sck;
  logic             mosi;
  logic             miso;
  logic [31:0]      rx_data;
  logic             rx_vld;
  logic [IDX_W-1:0] rx_idx;
  logic             frame_done;
  logic             frame_err;
  logic [31:0]      tx_data;
  logic             tx_empty;
  logic             tx_pop;

  modport slave (
    input  load, sck, mosi, tx_data, tx_empty,
    output miso, rx_data, rx_vld, rx_idx, frame_done, frame_err, tx_pop
  );

  modport master (
    output load, sck, mosi, tx_data, tx_empty,
    input  miso, rx_data, rx_vld, rx_idx, frame_done, frame_err, tx_pop
  );

endinterface

// File: rtl/api_sync_edge.sv
// -----------------------------------------------------------------------------
// api_sync_edge
// Brings one asynchronous pin into the clk domain through STAGES flops and
// keeps one history flop so rise/fall can be detected.
//   clk    system clock
//   rst_n  async active-low reset (all flops clear to 0)
//   din    raw pin
//   level  synchronised level
//   rise   one-cycle strobe, synchronised level went 0 -> 1
//   fall   one-cycle strobe, synchronised level went 1 -> 0
// Strobes are combinational from flops, so the registered action they trigger
// lands STAGES+1 clocks after the pin edge.
// -----------------------------------------------------------------------------
module api_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              hist_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= din;
        end
      end else begin : g_chain
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_reg <= 1'b0;
    else        hist_reg <= sync_reg[STAGES-1];
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~hist_reg;
  assign fall  = ~level & hist_reg;

endmodule

// File: rtl/api_spi_slave.sv
// -----------------------------------------------------------------------------
// api_spi_slave
// Chip-side responder of the work-distribution SPI link (mode 0, MSB first),
// oversampled in the clk domain. Deserialises a work frame of WORK_LEN words
// into a word stream and, in parallel, serialises result words from a FWFT
// queue onto miso.
//   clk    system clock
//   rst_n  async active-low reset; aborts any frame without status strobes
//   bus    api_spi_slave_if.slave: serial pins, rx stream, frame status,
//          result-queue head/empty/pop
// -----------------------------------------------------------------------------
module api_spi_slave
  import api_pkg::*;
#(
  parameter int          WORK_LEN    = WORK_LEN_DEF,
  parameter int          IDX_W       = 5,
  parameter logic [31:0] IDLE_WORD   = IDLE_WORD_DEF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  api_spi_slave_if.slave  bus
);

  localparam int               CNT_W     = $clog2(WORK_LEN + 1);
  localparam int               BIT_W     = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] WORDS_ALL = CNT_W'(WORK_LEN);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);

  // ---------------------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------------------
  logic load_lvl, load_rise, load_fall;
  logic sck_lvl_unused, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  api_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.load),
    .level (load_lvl),
    .rise  (load_rise),
    .fall  (load_fall)
  );

  api_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.sck),
    .level (sck_lvl_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  api_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.mosi),
    .level (mosi_lvl),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_reg,          state_next;
  logic [BIT_W-1:0]    bit_cnt_reg,        bit_cnt_next;
  logic [CNT_W-1:0]    word_cnt_reg,       word_cnt_next;
  logic [WORD_W-1:0]   rx_sr_reg,          rx_sr_next;
  logic [WORD_W-1:0]   tx_sr_reg,          tx_sr_next;
  logic                reload_pending_reg, reload_pending_next;
  logic [WORD_W-1:0]   rx_data_reg,        rx_data_next;
  logic [IDX_W-1:0]    rx_idx_reg,         rx_idx_next;
  logic                rx_vld_reg,         rx_vld_next;
  logic                frame_done_reg,     frame_done_next;
  logic                frame_err_reg,      frame_err_next;
  logic                tx_pop_reg,         tx_pop_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= ST_IDLE;
      bit_cnt_reg        <= '0;
      word_cnt_reg       <= '0;
      rx_sr_reg          <= '0;
      tx_sr_reg          <= '0;
      reload_pending_reg <= 1'b0;
      rx_data_reg        <= '0;
      rx_idx_reg         <= '0;
      rx_vld_reg         <= 1'b0;
      frame_done_reg     <= 1'b0;
      frame_err_reg      <= 1'b0;
      tx_pop_reg         <= 1'b0;
    end else begin
      state_reg          <= state_next;
      bit_cnt_reg        <= bit_cnt_next;
      word_cnt_reg       <= word_cnt_next;
      rx_sr_reg          <= rx_sr_next;
      tx_sr_reg          <= tx_sr_next;
      reload_pending_reg <= reload_pending_next;
      rx_data_reg        <= rx_data_next;
      rx_idx_reg         <= rx_idx_next;
      rx_vld_reg         <= rx_vld_next;
      frame_done_reg     <= frame_done_next;
      frame_err_reg      <= frame_err_next;
      tx_pop_reg         <= tx_pop_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next          = state_reg;
    bit_cnt_next        = bit_cnt_reg;
    word_cnt_next       = word_cnt_reg;
    rx_sr_next          = rx_sr_reg;
    tx_sr_next          = tx_sr_reg;
    reload_pending_next = reload_pending_reg;
    rx_data_next        = rx_data_reg;
    rx_idx_next         = rx_idx_reg;
    rx_vld_next         = 1'b0;
    frame_done_next     = 1'b0;
    frame_err_next      = 1'b0;
    tx_pop_next         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (load_rise) begin
          state_next          = ST_ACTIVE;
          bit_cnt_next        = '0;
          word_cnt_next       = '0;
          reload_pending_next = 1'b0;
          // First outgoing word must sit in the shifter before the first sck rise.
          tx_sr_next          = pick_tx(bus.tx_empty, bus.tx_data, IDLE_WORD);
          tx_pop_next         = ~bus.tx_empty;
        end
      end

      ST_ACTIVE: begin
        // load fall has priority over any sck edge seen in the same cycle;
        // a partial or just-completed word is dropped in that case.
        if (load_fall) begin
          state_next = ST_IDLE;
          if (word_cnt_reg == WORDS_ALL && bit_cnt_reg == '0) frame_done_next = 1'b1;
          else                                                 frame_err_next  = 1'b1;
        end else if (sck_rise) begin
          rx_sr_next = {rx_sr_reg[WORD_W-2:0], mosi_lvl};
          if (bit_cnt_reg == BIT_LAST) begin
            if (word_cnt_reg == WORDS_ALL) begin
              // Overlong frame: park in ERR until the controller drops load.
              state_next = ST_ERR;
            end else begin
              rx_vld_next         = 1'b1;
              rx_data_next        = {rx_sr_reg[WORD_W-2:0], mosi_lvl};
              rx_idx_next         = IDX_W'(word_cnt_reg);
              word_cnt_next       = word_cnt_reg + 1'b1;
              bit_cnt_next        = '0;
              reload_pending_next = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else if (sck_fall) begin
          // The fall after a completed word starts the next word slot, so the
          // shifter reloads instead of shifting; at most one pop per slot.
          if (reload_pending_reg) begin
            tx_sr_next          = pick_tx(bus.tx_empty, bus.tx_data, IDLE_WORD);
            tx_pop_next         = ~bus.tx_empty;
            reload_pending_next = 1'b0;
          end else begin
            tx_sr_next = {tx_sr_reg[WORD_W-2:0], 1'b0};
          end
        end
      end

      ST_ERR: begin
        if (load_fall) begin
          state_next     = ST_IDLE;
          frame_err_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.miso       = load_lvl & tx_sr_reg[WORD_W-1];
  assign bus.rx_data    = rx_data_reg;
  assign bus.rx_vld     = rx_vld_reg;
  assign bus.rx_idx     = rx_idx_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.frame_err  = frame_err_reg;
  assign bus.tx_pop     = tx_pop_reg;

endmodule

// File: tb/tb_api_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_api_spi_slave
// Directed bench for api_spi_slave: drives SPI mode-0 frames, models the FWFT
// result queue, logs rx strobes and checks against hand-computed values.
// -----------------------------------------------------------------------------
module tb_api_spi_slave;

  localparam int HALF = 4;   // clk periods per sck phase
  localparam int LOGN = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  api_spi_slave_if #(.IDX_W(5)) bus ();

  api_spi_slave #(
    .WORK_LEN    (23),
    .IDX_W       (5),
    .IDLE_WORD   (32'h0000_0000),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Result-queue model: initial block fills, monitor advances head on pop.
  logic [31:0] tx_q [16];
  int          q_len = 0;
  int          head  = 0;
  assign bus.tx_empty = (head >= q_len);
  assign bus.tx_data  = (head < q_len) ? tx_q[head] : 32'hDEAD_BEEF;

  // Monitor-owned logs and counters.
  logic [4:0]  rx_idx_log  [LOGN];
  logic [31:0] rx_data_log [LOGN];
  int rx_total = 0, done_total = 0, err_total = 0, pop_total = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_vld && rx_total < LOGN) begin
        rx_idx_log[rx_total]  <= bus.rx_idx;
        rx_data_log[rx_total] <= bus.rx_data;
        rx_total              <= rx_total + 1;
      end
      if (bus.frame_done) done_total <= done_total + 1;
      if (bus.frame_err)  err_total  <= err_total + 1;
      if (bus.tx_pop) begin
        pop_total <= pop_total + 1;
        head      <= head + 1;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] miso_log [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nbits of w (MSB first); r collects miso sampled just before each rise.
  task automatic spi_word(input logic [31:0] w, input int nbits, output logic [31:0] r);
    r = '0;
    for (int b = 31; b > 31 - nbits; b--) begin
      bus.mosi = w[b];
      wait_clk(HALF);
      r[b] = bus.miso;
      bus.sck = 1'b1;
      wait_clk(HALF);
      bus.sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    bus.load = 1'b1;
    wait_clk(8);
  endtask

  task automatic frame_end(input int gap);
    wait_clk(HALF);
    bus.load = 1'b0;
    wait_clk(gap);
  endtask

  task automatic send_words(input logic [31:0] base, input int nwords, input int extra_bits);
    logic [31:0] r;
    for (int i = 0; i < nwords; i++) begin
      spi_word(base + 32'(i), 32, r);
      if (i < 32) miso_log[i] = r;
    end
    if (extra_bits > 0) spi_word(base + 32'(nwords), extra_bits, r);
  endtask

  task automatic check_rx(input string tag, input int start, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_idx"},  32'(rx_idx_log[start + i]), 32'(i));
      chk({tag, "_data"}, rx_data_log[start + i], base + 32'(i));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_miso"},  32'(bus.miso),       32'd0);
    chk({tag, "_vld"},   32'(bus.rx_vld),     32'd0);
    chk({tag, "_data"},  bus.rx_data,         32'd0);
    chk({tag, "_idx"},   32'(bus.rx_idx),     32'd0);
    chk({tag, "_done"},  32'(bus.frame_done), 32'd0);
    chk({tag, "_err"},   32'(bus.frame_err),  32'd0);
    chk({tag, "_pop"},   32'(bus.tx_pop),     32'd0);
  endtask

  int rx0, dn0, er0, pp0;

  task automatic snap();
    rx0 = rx_total; dn0 = done_total; er0 = err_total; pp0 = pop_total;
  endtask

  task automatic check_counts(input string tag, input int rx, input int dn, input int er, input int pp);
    chk({tag, "_rx_cnt"},   32'(rx_total - rx0),   32'(rx));
    chk({tag, "_done_cnt"}, 32'(done_total - dn0), 32'(dn));
    chk({tag, "_err_cnt"},  32'(err_total - er0),  32'(er));
    chk({tag, "_pop_cnt"},  32'(pop_total - pp0),  32'(pp));
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.load = 1'b0;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    wait_clk(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    wait_clk(5);

    // Good frame, two queued results.
    tx_q[0] = 32'hA5A5_A5A5;
    tx_q[1] = 32'h5A5A_5A5A;
    q_len   = 2;
    snap();
    frame_begin();
    send_words(32'h1, 23, 0);
    frame_end(10);
    check_counts("good", 23, 1, 0, 2);
    check_rx("good", rx0, 23, 32'h1);
    chk("good_miso0", miso_log[0], 32'hA5A5_A5A5);
    chk("good_miso1", miso_log[1], 32'h5A5A_5A5A);
    for (int i = 2; i < 23; i++) chk("good_miso_idle", miso_log[i], 32'h0);
    $display("txn good frame: rx=%0d done=%0d pops=%0d", rx_total - rx0, done_total - dn0, pop_total - pp0);

    // Whole frame with an empty result queue.
    snap();
    frame_begin();
    send_words(32'h100, 23, 0);
    frame_end(10);
    check_counts("empty", 23, 1, 0, 0);
    check_rx("empty", rx0, 23, 32'h100);
    for (int i = 0; i < 23; i++) chk("empty_miso", miso_log[i], 32'h0);
    $display("txn empty-queue frame: rx=%0d done=%0d pops=%0d", rx_total - rx0, done_total - dn0, pop_total - pp0);

    // Short frame: 10 words + 7 bits.
    snap();
    frame_begin();
    send_words(32'h200, 10, 7);
    frame_end(10);
    check_counts("short", 10, 0, 1, 0);
    check_rx("short", rx0, 10, 32'h200);
    $display("txn short frame: rx=%0d err=%0d", rx_total - rx0, err_total - er0);

    // Overlong frame: 24 words.
    snap();
    frame_begin();
    send_words(32'h300, 24, 0);
    frame_end(10);
    check_counts("long", 23, 0, 1, 0);
    check_rx("long", rx0, 23, 32'h300);
    $display("txn overlong frame: rx=%0d err=%0d", rx_total - rx0, err_total - er0);

    // Reset in the middle of word 5, bit 12; then a clean frame.
    snap();
    frame_begin();
    send_words(32'h400, 5, 12);
    check_rx("pre_rst", rx0, 5, 32'h400);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    bus.load = 1'b0;
    bus.sck  = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    chk("midrst_no_status", 32'((done_total - dn0) + (err_total - er0)), 32'd0);
    rx0 = rx_total;
    frame_begin();
    send_words(32'h500, 23, 0);
    frame_end(10);
    check_counts("after_rst", 23, 1, 0, 0);
    check_rx("after_rst", rx0, 23, 32'h500);
    $display("txn reset-abort then frame: rx=%0d done=%0d err=%0d", rx_total - rx0, done_total - dn0, err_total - er0);

    // Back-to-back frames with a 4-clk load gap; new head arrives in the gap.
    tx_q[2] = 32'hC3C3_0F0F;
    q_len   = 3;
    snap();
    frame_begin();
    send_words(32'h600, 23, 0);
    chk("b2b_a_miso0", miso_log[0], 32'hC3C3_0F0F);
    chk("b2b_a_miso1", miso_log[1], 32'h0);
    frame_end(0);
    tx_q[3] = 32'h1234_5678;
    q_len   = 4;
    wait_clk(4);
    frame_begin();
    send_words(32'h700, 23, 0);
    frame_end(10);
    chk("b2b_b_miso0", miso_log[0], 32'h1234_5678);
    check_counts("b2b", 46, 2, 0, 2);
    check_rx("b2b_a", rx0, 23, 32'h600);
    check_rx("b2b_b", rx0 + 23, 23, 32'h700);
    $display("txn back-to-back: rx=%0d done=%0d pops=%0d", rx_total - rx0, done_total - dn0, pop_total - pp0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/api_spi_slave.md
Name: api_spi_slave

Overview:
- Chip-side responder for the work-distribution serial link driven by the API controller: load (frame select), sck, mosi in; miso out.
- Deserialises one work frame of WORK_LEN 32-bit words into a word stream for the hashing core.
- Concurrently serialises result words from a first-word-fall-through result queue back on miso.
- Oversampled entirely in the local clock domain; sck is never used as a clock.

Parameters:
- WORK_LEN, 23, words per valid work frame (736 bits / 32).
- IDX_W, 5, width of the word index; must satisfy 2**IDX_W >= WORK_LEN.
- IDLE_WORD, 32'h0000_0000, word shifted out on miso when the result queue is empty.
- SYNC_STAGES, 2, synchroniser depth on load/sck/mosi.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- load  in  1  frame select, high = frame active
- sck  in  1  serial clock from the controller
- mosi  in  1  serial data in, MSB first
- miso  out  1  serial data out, MSB first
- rx_data  out  32  received word
- rx_vld  out  1  one-cycle strobe, rx_data/rx_idx valid
- rx_idx  out  IDX_W  word index within the frame, 0..WORK_LEN-1
- frame_done  out  1  one-cycle strobe, complete good frame
- frame_err  out  1  one-cycle strobe, malformed frame
- tx_data  in  32  head of the result queue (FWFT)
- tx_empty  in  1  result queue empty
- tx_pop  out  1  one-cycle pop of the result queue

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: miso=0, rx_vld=0, rx_data=0, rx_idx=0, frame_done=0, frame_err=0, tx_pop=0. All synchroniser flops reset to 0, the FSM to IDLE, and all counters to 0.
- Sampling and timing:
  - load, sck and mosi each pass through SYNC_STAGES flops plus one history flop for edge detection.
  - sck high and low phases must each be at least 4 clk periods.
  - Pin edge to internal action latency is SYNC_STAGES+1 clk (3 at default).
- SPI mode 0:
  - mosi is sampled on sck rise.
  - miso changes on sck fall.
  - miso = tx_sr[31] while the synchronised load is high; otherwise 0.
- FSM states: IDLE, ACTIVE, ERR.
  - IDLE -> ACTIVE on load rise. Clear bit_cnt(0..31) and word_cnt.
  - IDLE -> ACTIVE preload: tx_sr <= tx_empty ? IDLE_WORD : tx_data. Pulse tx_pop in the same cycle if !tx_empty.
  - ACTIVE, sck rise: rx_sr <= {rx_sr[30:0], sync mosi}; bit_cnt++.
  - ACTIVE, sck rise with bit_cnt==31 and word_cnt<WORK_LEN:
    - next cycle, rx_vld=1, rx_data=completed word, rx_idx=word_cnt.
    - word_cnt++ and bit_cnt wraps to 0.
    - set reload_pending.
  - ACTIVE, sck rise with bit_cnt==31 and word_cnt==WORK_LEN: go to ERR. No rx_vld. Overlong frame.
  - ACTIVE, sck fall with reload_pending: tx_sr <= tx_empty ? IDLE_WORD : tx_data. Pop if !tx_empty. Clear reload_pending.
  - ACTIVE, sck fall without reload_pending: tx_sr <= tx_sr << 1.
  - ACTIVE, load fall, good frame (word_cnt==WORK_LEN and bit_cnt==0): frame_done pulse, -> IDLE.
  - ACTIVE, load fall, otherwise: frame_err pulse, -> IDLE. Any partial word is discarded.
  - ERR: ignore sck. On load fall, frame_err pulse, -> IDLE.
- Never more than one tx_pop per word slot.
- Maximum pops per frame = WORK_LEN+1: the preload plus one per completed word. The final reload lands on the trailing sck fall, if that fall occurs.
- Simultaneous events:
  - load fall in the same cycle as an sck edge: the load fall wins and the sck edge is ignored.
  - A sck rise completing the last word in the same cycle as load fall cannot occur under the timing rule above. If it does, the word is discarded and frame_err fires.
- A load pulse with no sck edges yields frame_err and pops exactly one word (the preload). The controller must not issue empty frames.
- Async reset mid-frame aborts immediately. No frame_done or frame_err is emitted. Any popped tx word is lost.
- rx_vld has no backpressure; the consumer must accept every strobe.

Decomposition:
- Shared package api_pkg: WORD_W=32, WORK_LEN default, IDLE_WORD default, FSM state encoding.
- Sub-module api_sync_edge: per-signal synchroniser with rise/fall strobes. Instantiate it for load, sck and mosi (mosi uses level only).
- Shift, counter and FSM logic stays in api_spi_slave.

Test Plan:
- Good frame: 23 words 0x00000001..0x00000017, tx queue holds 0xA5A5A5A5 and 0x5A5A5A5A.
  - rx_vld ×23 with rx_idx 0..22 and matching data; one frame_done.
  - miso carries 0xA5A5A5A5, 0x5A5A5A5A, then IDLE_WORD.
  - tx_pop ×2.
- Empty tx queue for a whole frame -> miso all 0 for 736 bits; tx_pop never asserted; frame_done=1.
- Short frame: load drops after 10 words + 7 bits -> rx_vld ×10; frame_err once; no frame_done.
- Overlong frame: 24 words -> rx_vld ×23 only; no strobe for word 24; ERR until load falls; then frame_err once.
- Async reset asserted at word 5, bit 12 -> all outputs 0 within the reset assertion. The next full frame after release produces 23 rx_vld and frame_done.
- Back-to-back frames, load low for 4 clk between them -> two frame_done pulses; rx_idx restarts at 0; the second frame's first miso bit is the new queue head's MSB.
